mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit for the custom CPU. It accepts one operand pair plus an M-extension function code over a valid/ready request channel and computes the result with a radix-2 shift-add multiplier or a restoring divider, one bit per cycle. It returns the 32-bit result over a valid/ready response channel. The CPU execute stage issues to it for every MUL/DIV/REM-class instruction and stalls until the response arrives; the combinational ALU is not involved.

---
 rtl/mdu_iter.sv | 149 ++++++++++++++
 tb/tb_mdu_iter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider, one bit per cycle, behind valid/ready request/response channels.
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic [1:0]            dbg_state
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the request side is ready only in IDLE, the response side is
  // valid only in DONE, and resp_result is held until the response transfers.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t state, state_d;

  logic [5:0]   cnt;
  logic [2:0]   op_q;
  logic         neg_q;
  logic         neg_r;
  logic [63:0]  acc;
  logic [63:0]  mcand;
  logic [W-1:0] dq;

  logic         accept;
  logic         a_signed, b_signed, sign_a, sign_b;
  logic [W-1:0] mag_a, mag_b;
  logic         div_by_zero, div_ovf, special;
  logic [W-1:0] special_result;

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign dbg_state  = state;
  assign accept     = req_valid && req_ready;

  // Operand decode on the raw request; only meaningful while accepting.
  always_comb begin
    a_signed       = (req_op == 3'b001) || (req_op == 3'b010) ||
                     (req_op == 3'b100) || (req_op == 3'b110);
    b_signed       = (req_op == 3'b001) || (req_op == 3'b100) || (req_op == 3'b110);
    sign_a         = a_signed && req_a[W-1];
    sign_b         = b_signed && req_b[W-1];
    mag_a          = sign_a ? (W'(0) - req_a) : req_a;
    mag_b          = sign_b ? (W'(0) - req_b) : req_b;
    div_by_zero    = req_op[2] && (req_b == '0);
    div_ovf        = req_op[2] && !req_op[0] && (req_a == MIN_INT) && (req_b == '1);
    special        = div_by_zero || div_ovf;
    special_result = '0;
    if (div_by_zero) special_result = req_op[1] ? req_a : '1;
    else if (div_ovf) special_result = req_op[1] ? '0 : MIN_INT;
  end

  // One restoring-division step: shift the next dividend bit into the remainder.
  logic [32:0] div_shifted;
  logic [33:0] div_diff;
  assign div_shifted = {acc[31:0], dq[W-1]};
  assign div_diff    = {1'b0, div_shifted} - {2'b00, mcand[31:0]};

  // Sign fix-up and result selection used in FIX.
  logic [63:0]  prod_fix;
  logic [W-1:0] quo_fix, rem_fix, fix_result;
  always_comb begin
    prod_fix   = neg_q ? (64'd0 - acc) : acc;
    quo_fix    = neg_q ? (W'(0) - dq) : dq;
    rem_fix    = neg_r ? (W'(0) - acc[31:0]) : acc[31:0];
    fix_result = '0;
    if (op_q[2])              fix_result = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00) fix_result = prod_fix[31:0];
    else                      fix_result = prod_fix[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
      S_CALC: if (cnt == 6'd31) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      dq          <= '0;
      resp_result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (special) begin
              resp_result <= special_result;
            end else begin
              op_q  <= req_op;
              cnt   <= '0;
              neg_q <= sign_a ^ sign_b;
              neg_r <= sign_a;
              acc   <= '0;
              // Multiply: mcand = |a| shifted left, dq = |b| shifted right.
              // Divide:   mcand = |b| divisor, dq = |a| dividend becoming quotient.
              mcand <= {32'd0, req_op[2] ? mag_b : mag_a};
              dq    <= req_op[2] ? mag_a : mag_b;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + 6'd1;
          if (!op_q[2]) begin
            if (dq[0]) acc <= acc + mcand;
            mcand <= {mcand[62:0], 1'b0};
            dq    <= {1'b0, dq[W-1:1]};
          end else if (!div_diff[33]) begin
            acc <= {31'd0, div_diff[32:0]};
            dq  <= {dq[W-2:0], 1'b1};
          end else begin
            acc <= {31'd0, div_shifted};
            dq  <= {dq[W-2:0], 1'b0};
          end
        end
        S_FIX: resp_result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed RV32M cases, timing, backpressure,
// mid-operation reset and a random regression against a 64-bit reference model.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_errors;

  mdu_iter #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired: got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int          ia, ib;
    logic        ovf;
    logic [31:0] r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if (op[2] && !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
    return 34;
  endfunction

  // Driver + response check for one operation. Called at a falling edge.
  // hold: cycles resp_ready stays low after resp_valid; poke: pulse req_valid
  // during the hold, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit poke);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    exp_q.push_back(ref_model(op, a, b));
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!resp_valid) begin
      check("resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
      return;
    end
    check("latency", 32'(cyc), 32'(ref_latency(op, a, b)));
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 2) begin
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 32'd1;
        req_b     = 32'd1;
      end
      check("hold_result", resp_result, exp_q[0]);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
    end
    check("result", resp_result, exp_q.pop_front());
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("idle_after_resp", {31'd0, req_ready}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] edges [5];
    edges = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
    return $urandom;
  endfunction

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_result", resp_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // multiply
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    // divide
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd5, 32'd100, 32'd7, 0, 0);
    run_op(3'd7, 32'd100, 32'd7, 0, 0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 0, 0);
    // special cases
    run_op(3'd5, 32'd5, 32'd0, 0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    // backpressure with ignored request pulse, then immediate next accept
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1);
    run_op(3'd0, 32'd6, 32'd9, 0, 0);

    // mid-divide reset
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'd1000;
    req_b     = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_busy", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("async_rst_resp_result", resp_result, 32'd0);
    check("async_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    run_op(3'd0, 32'd3, 32'd4, 0, 0);

    // random regression
    for (int n = 0; n < 1000; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(op, a, b, $urandom_range(0, 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
